// File: rtl/mod_exp_ctrl.sv
// Modular exponentiation controller: converts BASE into the Montgomery domain by repeated doubling,
// then runs MSB-first square-and-multiply on an external Montgomery multiplier.
module mod_exp_ctrl (
    input  logic        pclk,
    input  logic        reset,
    input  logic        GO,
    input  logic [63:0] BASE,
    input  logic [63:0] EXP,
    input  logic [63:0] M,
    output logic        mm_go,
    output logic [63:0] mm_a,
    output logic [63:0] mm_b,
    output logic [63:0] mm_m,
    input  logic [65:0] mm_p,
    input  logic        mm_ready,
    output logic [63:0] RESULT,
    output logic        BUSY,
    output logic        DONE
);

    typedef enum logic [2:0] {
        StIdle, StConv, StSqr, StMul, StFin, StGap, StDone
    } state_e;

    state_e      state_q, state_d;
    state_e      after_gap_q, after_gap_d;
    logic        go_prev_q, go_prev_d;
    logic        armed_q, armed_d;
    logic [63:0] exp_q, exp_d;
    logic [63:0] m_q, m_d;
    logic [64:0] x_q, x_d;
    logic [64:0] rm_q, rm_d;
    logic [63:0] acc_q, acc_d;
    logic [5:0]  idx_q, idx_d;
    logic [5:0]  conv_cnt_q, conv_cnt_d;
    logic [63:0] result_q, result_d;
    logic        start;

    // Upper product bits carry no information once the multiplier result is reduced.
    logic unused_mm_p_hi;
    assign unused_mm_p_hi = ^mm_p[65:64];

    // Full 66-bit compare so moduli near 2^64 reduce correctly.
    function automatic logic [64:0] dbl_mod(input logic [64:0] v, input logic [63:0] m);
        logic [65:0] two;
        two = {v, 1'b0};
        if (two >= {2'b00, m}) begin
            return 65'(two - {2'b00, m});
        end
        return 65'(two);
    endfunction

    // Armed only after GO has been seen low, so GO held through reset cannot start an operation.
    assign start = GO && !go_prev_q && armed_q && (state_q == StIdle || state_q == StDone);

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q     <= StIdle;
            after_gap_q <= StIdle;
            go_prev_q   <= 1'b0;
            armed_q     <= 1'b0;
            exp_q       <= '0;
            m_q         <= '0;
            x_q         <= '0;
            rm_q        <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            conv_cnt_q  <= '0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            after_gap_q <= after_gap_d;
            go_prev_q   <= go_prev_d;
            armed_q     <= armed_d;
            exp_q       <= exp_d;
            m_q         <= m_d;
            x_q         <= x_d;
            rm_q        <= rm_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            conv_cnt_q  <= conv_cnt_d;
            result_q    <= result_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        after_gap_d = after_gap_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) state_d = StConv;
            end
            StConv: begin
                if (conv_cnt_q == 6'd63) state_d = StSqr;
            end
            StSqr: begin
                if (mm_ready) begin
                    state_d = StGap;
                    if (exp_q[idx_q])        after_gap_d = StMul;
                    else if (idx_q == 6'd0)  after_gap_d = StFin;
                    else                     after_gap_d = StSqr;
                end
            end
            StMul: begin
                if (mm_ready) begin
                    state_d     = StGap;
                    after_gap_d = (idx_q == 6'd0) ? StFin : StSqr;
                end
            end
            StFin: begin
                if (mm_ready) begin
                    state_d     = StGap;
                    after_gap_d = StDone;
                end
            end
            StGap:   state_d = after_gap_q;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        go_prev_d  = GO;
        armed_d    = armed_q | ~GO;
        exp_d      = exp_q;
        m_d        = m_q;
        x_d        = x_q;
        rm_d       = rm_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        conv_cnt_d = conv_cnt_q;
        result_d   = result_q;
        if (start) begin
            exp_d      = EXP;
            m_d        = M;
            x_d        = {1'b0, BASE};
            rm_d       = 65'd1;
            conv_cnt_d = 6'd0;
        end
        unique case (state_q)
            StConv: begin
                x_d        = dbl_mod(x_q, m_q);
                rm_d       = dbl_mod(rm_q, m_q);
                conv_cnt_d = conv_cnt_q + 6'd1;
                if (conv_cnt_q == 6'd63) begin
                    acc_d = rm_d[63:0];
                    idx_d = 6'd63;
                end
            end
            StSqr: begin
                if (mm_ready) begin
                    acc_d = mm_p[63:0];
                    if (!exp_q[idx_q] && idx_q != 6'd0) idx_d = idx_q - 6'd1;
                end
            end
            StMul: begin
                if (mm_ready) begin
                    acc_d = mm_p[63:0];
                    if (idx_q != 6'd0) idx_d = idx_q - 6'd1;
                end
            end
            StFin: begin
                if (mm_ready) result_d = mm_p[63:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        mm_go  = (state_q == StSqr) || (state_q == StMul) || (state_q == StFin);
        mm_a   = acc_q;
        mm_b   = acc_q;
        if (state_q == StMul) mm_b = x_q[63:0];
        if (state_q == StFin) mm_b = 64'd1;
        mm_m   = m_q;
        RESULT = result_q;
        BUSY   = (state_q != StIdle) && (state_q != StDone);
        DONE   = (state_q == StDone);
    end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Bench for mod_exp_ctrl: behavioural Montgomery multiplier with configurable latency,
// handshake monitor, and a plain square-and-multiply reference model.
module tb_mod_exp_ctrl;

    logic        pclk = 1'b0;
    logic        reset = 1'b1;
    logic        GO = 1'b0;
    logic [63:0] BASE = '0, EXP = '0, M = '0;
    logic        mm_go;
    logic [63:0] mm_a, mm_b, mm_m;
    logic [65:0] mm_p = '0;
    logic        mm_ready = 1'b0;
    logic [63:0] RESULT;
    logic        BUSY, DONE;

    int n_checks = 0;
    int n_fail   = 0;
    int mult_lat = 2;
    int mcnt     = 0;
    int mon_rises = 0, mon_hs = 0, mon_viol = 0;
    logic        prev_go = 1'b0, prev_ready = 1'b0, prev_hs = 1'b0;
    logic [63:0] hold_a = '0, hold_b = '0;

    mod_exp_ctrl dut (
        .pclk(pclk), .reset(reset), .GO(GO), .BASE(BASE), .EXP(EXP), .M(M),
        .mm_go(mm_go), .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m), .mm_p(mm_p),
        .mm_ready(mm_ready), .RESULT(RESULT), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 pclk = ~pclk;

    function automatic logic [65:0] mont(input logic [63:0] a, input logic [63:0] b,
                                         input logic [63:0] m);
        logic [129:0] t;
        t = '0;
        if (m == 64'd0) return '0;
        for (int i = 0; i < 64; i++) begin
            if (a[i]) t = t + {66'd0, b};
            if (t[0]) t = t + {66'd0, m};
            t = t >> 1;
        end
        t = t % {66'd0, m};
        return t[65:0];
    endfunction

    function automatic logic [63:0] ref_modexp(input logic [63:0] base, input logic [63:0] e,
                                               input logic [63:0] m);
        logic [127:0] r, b, mm;
        mm = {64'd0, m};
        r  = 128'd1 % mm;
        b  = {64'd0, base} % mm;
        for (int i = 63; i >= 0; i--) begin
            r = (r * r) % mm;
            if (e[i]) r = (r * b) % mm;
        end
        return r[63:0];
    endfunction

    function automatic int exp_cycles(input logic [63:0] e, input int lat);
        return 1 + 64 + (64 + $countones(e) + 1) * (lat + 2);
    endfunction

    // Multiplier: result presented mult_lat sampled cycles after mm_go is first seen high.
    always @(posedge pclk) begin
        if (reset) begin
            mm_ready <= 1'b0;
            mcnt     <= 0;
        end else if (mm_go && !mm_ready) begin
            if (mcnt >= mult_lat - 1) begin
                mm_ready <= 1'b1;
                mm_p     <= mont(mm_a, mm_b, mm_m);
                mcnt     <= 0;
            end else begin
                mcnt <= mcnt + 1;
            end
        end else begin
            mm_ready <= 1'b0;
        end
    end

    // Handshake monitor: operand stability, one low cycle after each result, no rise on ready.
    always @(posedge pclk) begin
        if (!reset) begin
            if (mm_go && !prev_go) begin
                mon_rises <= mon_rises + 1;
                if (prev_ready) mon_viol <= mon_viol + 1;
            end
            if (mm_go && prev_go && (mm_a !== hold_a || mm_b !== hold_b)) mon_viol <= mon_viol + 1;
            if (mm_go && prev_hs) mon_viol <= mon_viol + 1;
            if (mm_go && mm_ready) mon_hs <= mon_hs + 1;
        end
        prev_go    <= mm_go;
        prev_ready <= mm_ready;
        prev_hs    <= mm_go && mm_ready;
        hold_a     <= mm_a;
        hold_b     <= mm_b;
    end

    function automatic logic [63:0] rand_odd_mod();
        logic [63:0] m;
        m = {$urandom, $urandom} | 64'd1;
        if (m == 64'd1) m = 64'd3;
        return m;
    endfunction

    task automatic do_run(input logic [63:0] b, input logic [63:0] e, input logic [63:0] m,
                          output logic [63:0] res, output int cycles, output int rises,
                          output int hs, output logic busy_at_done, output logic timed_out);
        int r0, h0;
        BASE = b; EXP = e; M = m;
        @(negedge pclk);
        GO = 1'b1;
        r0 = mon_rises;
        h0 = mon_hs;
        @(negedge pclk);
        GO = 1'b0;
        cycles = 1;
        // Latched operands must not follow later input changes.
        BASE = {$urandom, $urandom}; EXP = {$urandom, $urandom}; M = {$urandom, $urandom};
        while (DONE !== 1'b1 && cycles < 20000) begin
            @(negedge pclk);
            cycles++;
        end
        timed_out    = (DONE !== 1'b1);
        busy_at_done = BUSY;
        res          = RESULT;
        rises        = mon_rises - r0;
        hs           = mon_hs - h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        GO = 1'b1;
        repeat (3) @(negedge pclk);
        n_checks++;
        if ({mm_go, BUSY, DONE} !== 3'b000 || mm_a !== 64'd0 || mm_b !== 64'd0 ||
            mm_m !== 64'd0 || RESULT !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_state: go=%b busy=%b done=%b a=%h b=%h m=%h res=%h, need all zero",
                     mm_go, BUSY, DONE, mm_a, mm_b, mm_m, RESULT);
        end
        reset = 1'b0;
        repeat (5) @(negedge pclk);
        n_checks++;
        if (BUSY !== 1'b0 || mm_go !== 1'b0) begin
            n_fail++;
            $display("FAIL go_held_through_reset: busy=%b mm_go=%b, need 0 0", BUSY, mm_go);
        end
        GO = 1'b0;
        repeat (2) @(negedge pclk);
    endtask

    task automatic test_directed();
        logic [63:0] res;
        int cyc, rises, hs;
        logic bad, to;
        mult_lat = 2;
        do_run(64'd4, 64'd13, 64'd497, res, cyc, rises, hs, bad, to);
        n_checks++;
        if (to || res !== 64'd445) begin
            n_fail++;
            $display("FAIL directed_result: got %0d (timeout=%b), need 445", res, to);
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL directed_busy_at_done: got %b, need 0", bad);
        end
        n_checks++;
        if (cyc !== exp_cycles(64'd13, mult_lat)) begin
            n_fail++;
            $display("FAIL directed_latency: got %0d, need %0d", cyc, exp_cycles(64'd13, mult_lat));
        end
        n_checks++;
        if (rises !== 68 || hs !== 68) begin
            n_fail++;
            $display("FAIL directed_ops: rises=%0d hs=%0d, need 68 68", rises, hs);
        end
    endtask

    task automatic test_edge_cases();
        logic [63:0] tb_b [2] = '{64'd2, 64'd5};
        logic [63:0] tb_m [2] = '{64'd7, 64'd1};
        logic [63:0] tb_e [2] = '{64'd0, 64'd9};
        logic [63:0] tb_r [2] = '{64'd1, 64'd0};
        logic [63:0] res;
        int cyc, rises, hs;
        logic bad, to;
        mult_lat = 1;
        for (int k = 0; k < 2; k++) begin
            do_run(tb_b[k], tb_e[k], tb_m[k], res, cyc, rises, hs, bad, to);
            n_checks++;
            if (to || res !== tb_r[k]) begin
                n_fail++;
                $display("FAIL edge_result[%0d]: got %0d (timeout=%b), need %0d", k, res, to, tb_r[k]);
            end
            n_checks++;
            if (hs !== 64 + $countones(tb_e[k]) + 1 || cyc !== exp_cycles(tb_e[k], mult_lat)) begin
                n_fail++;
                $display("FAIL edge_ops[%0d]: hs=%0d cycles=%0d, need %0d %0d", k, hs, cyc,
                         64 + $countones(tb_e[k]) + 1, exp_cycles(tb_e[k], mult_lat));
            end
        end
    endtask

    task automatic test_popcount();
        logic [63:0] res;
        int cyc, rises, hs;
        logic bad, to;
        mult_lat = 3;
        do_run(64'd5, 64'd1000002, 64'd1000003, res, cyc, rises, hs, bad, to);
        n_checks++;
        if (to || res !== 64'd1) begin
            n_fail++;
            $display("FAIL fermat_result: got %0d (timeout=%b), need 1", res, to);
        end
        n_checks++;
        if (rises !== 64 + $countones(64'd1000002) + 1) begin
            n_fail++;
            $display("FAIL fermat_rises: got %0d, need %0d", rises, 64 + $countones(64'd1000002) + 1);
        end
    endtask

    task automatic test_full_width();
        logic [63:0] res, m;
        int cyc, rises, hs;
        logic bad, to;
        mult_lat = 1;
        m = 64'hFFFF_FFFF_FFFF_FFFF;
        do_run(m - 64'd1, 64'd3, m, res, cyc, rises, hs, bad, to);
        n_checks++;
        if (to || res !== 64'hFFFF_FFFF_FFFF_FFFE) begin
            n_fail++;
            $display("FAIL full_width: got %h (timeout=%b), need fffffffffffffffe", res, to);
        end
    endtask

    task automatic test_random();
        logic [63:0] res, b, e, m;
        int cyc, rises, hs;
        logic bad, to;
        for (int k = 0; k < 6; k++) begin
            mult_lat = $urandom_range(1, 4);
            m = (k < 2) ? ({32'd0, $urandom} | 64'd1) : rand_odd_mod();
            if (m == 64'd1) m = 64'd5;
            b = {$urandom, $urandom} % m;
            e = {$urandom, $urandom};
            do_run(b, e, m, res, cyc, rises, hs, bad, to);
            n_checks++;
            if (to || res !== ref_modexp(b, e, m)) begin
                n_fail++;
                $display("FAIL random_result[%0d]: got %h (timeout=%b), need %h", k, res, to,
                         ref_modexp(b, e, m));
            end
            n_checks++;
            if (cyc !== exp_cycles(e, mult_lat) || rises !== 64 + $countones(e) + 1) begin
                n_fail++;
                $display("FAIL random_timing[%0d]: cycles=%0d rises=%0d, need %0d %0d", k, cyc,
                         rises, exp_cycles(e, mult_lat), 64 + $countones(e) + 1);
            end
        end
    endtask

    task automatic test_go_hold();
        logic [63:0] b, e, m, want, res0;
        int cyc;
        logic stable;
        mult_lat = 1;
        m = rand_odd_mod();
        b = {$urandom, $urandom} % m;
        e = {$urandom, $urandom};
        want = ref_modexp(b, e, m);
        BASE = b; EXP = e; M = m;
        @(negedge pclk);
        GO = 1'b1;
        @(negedge pclk);
        cyc = 1;
        while (DONE !== 1'b1 && cyc < 20000) begin
            GO = (cyc < 150) ? cyc[2] : 1'b1;
            @(negedge pclk);
            cyc++;
        end
        n_checks++;
        if (DONE !== 1'b1 || RESULT !== want || cyc !== exp_cycles(e, mult_lat)) begin
            n_fail++;
            $display("FAIL toggle_while_busy: done=%b res=%h cycles=%0d, need 1 %h %0d", DONE,
                     RESULT, cyc, want, exp_cycles(e, mult_lat));
        end
        res0 = RESULT;
        stable = 1'b1;
        repeat (30) begin
            @(negedge pclk);
            if (DONE !== 1'b1 || BUSY !== 1'b0 || RESULT !== res0) stable = 1'b0;
        end
        n_checks++;
        if (stable !== 1'b1 || RESULT !== want) begin
            n_fail++;
            $display("FAIL go_held_after_done: stable=%b res=%h, need 1 %h", stable, RESULT, want);
        end
        GO = 1'b0;
        @(negedge pclk);
        GO = 1'b1;
        @(negedge pclk);
        GO = 1'b0;
        n_checks++;
        if (BUSY !== 1'b1 || DONE !== 1'b0) begin
            n_fail++;
            $display("FAIL fresh_edge_restart: busy=%b done=%b, need 1 0", BUSY, DONE);
        end
        cyc = 0;
        while (DONE !== 1'b1 && cyc < 20000) begin
            @(negedge pclk);
            cyc++;
        end
        n_checks++;
        if (DONE !== 1'b1 || RESULT !== want) begin
            n_fail++;
            $display("FAIL restart_result: done=%b res=%h, need 1 %h", DONE, RESULT, want);
        end
    endtask

    task automatic test_abort();
        logic [63:0] res, b, m;
        int cyc, rises, hs, r0, n;
        logic bad, to;
        mult_lat = 1;
        m = rand_odd_mod();
        BASE = {$urandom, $urandom} % m; EXP = 64'd0; M = m;
        @(negedge pclk);
        GO = 1'b1;
        r0 = mon_rises;
        @(negedge pclk);
        GO = 1'b0;
        n = 0;
        while (mon_rises - r0 < 10 && n < 5000) begin
            @(negedge pclk);
            n++;
        end
        n_checks++;
        if (n >= 5000 || mm_go !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_reach_10th_sqr: waited=%0d mm_go=%b, need <5000 1", n, mm_go);
        end
        reset = 1'b1;
        @(negedge pclk);
        n_checks++;
        if ({mm_go, BUSY, DONE} !== 3'b000) begin
            n_fail++;
            $display("FAIL abort_outputs: go/busy/done=%b, need 000", {mm_go, BUSY, DONE});
        end
        reset = 1'b0;
        repeat (2) @(negedge pclk);
        m = rand_odd_mod();
        b = {$urandom, $urandom} % m;
        do_run(b, 64'h0123_4567_89AB_CDEF, m, res, cyc, rises, hs, bad, to);
        n_checks++;
        if (to || res !== ref_modexp(b, 64'h0123_4567_89AB_CDEF, m)) begin
            n_fail++;
            $display("FAIL abort_rerun: got %h (timeout=%b), need %h", res, to,
                     ref_modexp(b, 64'h0123_4567_89AB_CDEF, m));
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_edge_cases();
        test_popcount();
        test_full_width();
        test_random();
        test_go_hold();
        test_abort();
        n_checks++;
        if (mon_viol !== 0) begin
            n_fail++;
            $display("FAIL handshake_protocol: %0d violations, need 0", mon_viol);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
